// File: rtl/oled_scan_ctrl_if.sv
// Pixel stream between the scan controller and the OLED serializer.
//   pix_data  : captured RGB565 pixel
//   pix_valid : pix_data valid
//   pix_ready : serializer accepts the pixel on a clock edge with pix_valid high
//   pix_last  : the pixel on the bus is the final pixel of the frame
// master = scan controller (producer), slave = serializer (consumer).
interface oled_scan_ctrl_if;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;

    modport master (output pix_data, output pix_valid, output pix_last, input pix_ready);
    modport slave  (input pix_data, input pix_valid, input pix_last, output pix_ready);
endinterface

// File: rtl/oled_scan_ctrl.sv
// Raster scan controller for a WIDTH x HEIGHT OLED.
// Presents x/y to the draw renderers, waits RENDER_LAT cycles for oled_data
// to settle, captures it and offers it to the serializer on the pix stream.
// Ports:
//   clk_25MHz   : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   frame_start : one-cycle request to scan a frame (honoured only when idle)
//   x, y        : pixel coordinate presented to the renderer
//   oled_data   : renderer output for the current x/y
//   pix         : pixel stream to the serializer (master side)
//   busy        : a frame is in progress
//   frame_done  : one-cycle pulse after the final pixel handshake
module oled_scan_ctrl #(
    parameter int unsigned WIDTH      = 96,
    parameter int unsigned HEIGHT     = 64,
    parameter int unsigned RENDER_LAT = 2
) (
    input  logic                    clk_25MHz,
    input  logic                    rst_n,
    input  logic                    frame_start,
    output logic [6:0]              x,
    output logic [6:0]              y,
    input  logic [15:0]             oled_data,
    oled_scan_ctrl_if.master        pix,
    output logic                    busy,
    output logic                    frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [6:0] X_LAST   = 7'(WIDTH - 1);
    localparam logic [6:0] Y_LAST   = 7'(HEIGHT - 1);
    localparam logic [3:0] LAT_INIT = 4'(RENDER_LAT - 1);

    state_t      state_q, state_d;
    logic [6:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [3:0]  lat_q, lat_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        last_px;

    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        lat_d   = lat_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    x_d     = '0;
                    y_d     = '0;
                    lat_d   = LAT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // lat_cnt reaching zero means oled_data now reflects x/y.
                if (lat_q != '0) begin
                    lat_d = lat_q - 4'd1;
                end else begin
                    data_d  = oled_data;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (pix.pix_ready) begin
                    valid_d = 1'b0;
                    if (last_px) begin
                        x_d     = '0;
                        y_d     = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + 7'd1;
                        end else begin
                            x_d = x_q + 7'd1;
                        end
                        lat_d   = LAT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign x             = x_q;
    assign y             = y_q;
    assign pix.pix_data  = data_q;
    assign pix.pix_valid = valid_q;
    assign pix.pix_last  = valid_q && last_px;
    assign busy          = (state_q != S_IDLE);
    assign frame_done    = done_q;

endmodule

// File: tb/tb_oled_scan_ctrl.sv
module tb_oled_scan_ctrl;

    localparam int W  = 96;
    localparam int H  = 64;
    localparam int N  = W * H;
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [6:0]  x, y;
    logic [15:0] oled_data;
    logic        busy, frame_done;
    logic [13:0] rend_q;

    logic        fs1;
    logic [6:0]  x1, y1;
    logic [15:0] oled_data1;
    logic        busy1, done1;

    int errors = 0;
    int checks = 0;

    oled_scan_ctrl_if pif ();
    oled_scan_ctrl_if pif1 ();

    oled_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .RENDER_LAT(RL)) dut (
        .clk_25MHz(clk), .rst_n(rst_n), .frame_start(frame_start),
        .x(x), .y(y), .oled_data(oled_data), .pix(pif),
        .busy(busy), .frame_done(frame_done)
    );

    oled_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .RENDER_LAT(1)) dut1 (
        .clk_25MHz(clk), .rst_n(rst_n), .frame_start(fs1),
        .x(x1), .y(y1), .oled_data(oled_data1), .pix(pif1),
        .busy(busy1), .frame_done(done1)
    );

    always #5 clk = ~clk;

    // Renderer with two-cycle latency: data reflects x/y one register later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rend_q <= '0;
        else        rend_q <= {x, y};
    end
    assign oled_data  = {2'b00, rend_q};
    assign oled_data1 = {2'b00, x1, y1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pixel index k of the frame, observed at the negedge
    // before the edge that acts on the sampled inputs.
    int k = 0, gap = 0, frames = 0;
    bit in_frame = 0, armed = 0, done_next = 0, idle_now;

    always @(negedge clk) begin
        if (!rst_n) begin
            k = 0; gap = 0; in_frame = 0; armed = 0; done_next = 0;
        end else begin
            idle_now = !in_frame;
            chk("frame_done", 32'(frame_done), 32'(done_next));
            done_next = 0;
            chk("busy", 32'(busy), 32'(in_frame));
            if (pif.pix_valid) begin
                chk("valid_in_frame", 32'(in_frame), 32'd1);
                chk("x", 32'(x), 32'(k % W));
                chk("y", 32'(y), 32'(k / W));
                chk("pix_data", 32'(pif.pix_data), 32'((k % W) * 128 + (k / W)));
                chk("pix_last", 32'(pif.pix_last), 32'(k == N - 1));
                if (armed) begin
                    chk("latency", 32'(gap), 32'(RL));
                    armed = 0;
                end
                if (pif.pix_ready) begin
                    k++;
                    if (k == N) begin
                        k = 0; in_frame = 0; done_next = 1; frames++;
                    end else begin
                        armed = 1; gap = 0;
                    end
                end
            end else if (armed) begin
                gap++;
            end
            if (frame_start && idle_now) begin
                in_frame = 1; armed = 1; gap = 0; k = 0;
            end
        end
    end

    typedef struct {
        bit          fs;
        bit          rdy;
        logic [6:0]  ex;
        logic [6:0]  ey;
        bit          ev;
        bit          eb;
        logic [15:0] ed;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n;
        bit seen;

        vecs[0]  = '{1, 1, 0, 0, 0, 1, 16'h0000};
        vecs[1]  = '{0, 1, 0, 0, 0, 1, 16'h0000};
        vecs[2]  = '{0, 1, 0, 0, 1, 1, 16'h0000};
        vecs[3]  = '{0, 1, 1, 0, 0, 1, 16'h0000};
        vecs[4]  = '{0, 0, 1, 0, 0, 1, 16'h0000};
        vecs[5]  = '{0, 0, 1, 0, 1, 1, 16'h0080};
        vecs[6]  = '{1, 0, 1, 0, 1, 1, 16'h0080};
        vecs[7]  = '{0, 0, 1, 0, 1, 1, 16'h0080};
        vecs[8]  = '{0, 1, 2, 0, 0, 1, 16'h0000};
        vecs[9]  = '{0, 1, 2, 0, 0, 1, 16'h0000};
        vecs[10] = '{0, 1, 2, 0, 1, 1, 16'h0100};

        rst_n = 1'b0; frame_start = 1'b0; pif.pix_ready = 1'b0;
        fs1 = 1'b0; pif1.pix_ready = 1'b0;
        repeat (3) step();
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_valid", 32'(pif.pix_valid), 0);
        chk("rst_data", 32'(pif.pix_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        rst_n = 1'b1;
        step();

        // Frame 1: opening cycles from a table, then run to completion.
        for (int i = 0; i < 11; i++) begin
            frame_start = vecs[i].fs;
            pif.pix_ready = vecs[i].rdy;
            step();
            chk("tbl_x", 32'(x), 32'(vecs[i].ex));
            chk("tbl_y", 32'(y), 32'(vecs[i].ey));
            chk("tbl_valid", 32'(pif.pix_valid), 32'(vecs[i].ev));
            chk("tbl_busy", 32'(busy), 32'(vecs[i].eb));
            if (vecs[i].ev) chk("tbl_data", 32'(pif.pix_data), 32'(vecs[i].ed));
        end
        frame_start = 1'b0;
        pif.pix_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 25000 && !seen; i++) begin
            step();
            if (frame_done) seen = 1;
        end
        chk("frame1_done_seen", 32'(seen), 1);

        // Frame 2 requested in the frame_done cycle; ready held high.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("f2_busy", 32'(busy), 1);
        n = 0;
        seen = 0;
        for (int i = 1; i < 20000 && !seen; i++) begin
            step();
            if (frame_done) begin
                seen = 1; n = i;
            end
        end
        chk("f2_done_edge", 32'(n), 32'(3 * N));

        // Frame 3 requested in the frame_done cycle: starts at (0,0).
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("f3_busy", 32'(busy), 1);
        chk("f3_x", 32'(x), 0);
        chk("f3_y", 32'(y), 0);
        chk("f3_valid", 32'(pif.pix_valid), 0);

        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (pif.pix_valid && x == 7'd5) seen = 1;
            else step();
        end
        chk("bp_reach_5", 32'(seen), 1);
        pif.pix_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(pif.pix_valid), 1);
            chk("bp_x", 32'(x), 5);
            chk("bp_y", 32'(y), 0);
            chk("bp_data", 32'(pif.pix_data), 32'h0280);
        end
        pif.pix_ready = 1'b1;
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            step();
            if (pif.pix_valid && x == 7'd6) n = i;
        end
        chk("bp_resume_edges", 32'(n), 32'(RL + 1));

        // Rest of frame 3: random backpressure and stray frame_start pulses.
        seen = 0;
        for (int i = 0; i < 40000 && !seen; i++) begin
            pif.pix_ready = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 50) == 0);
            step();
            if (frame_done) seen = 1;
        end
        frame_start = 1'b0;
        chk("frame3_done_seen", 32'(seen), 1);
        chk("frames", 32'(frames), 3);

        // Frame 4: reset mid-scan.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            pif.pix_ready = $urandom_range(0, 1);
            step();
        end
        rst_n = 1'b0;
        #2;
        chk("mid_rst_x", 32'(x), 0);
        chk("mid_rst_y", 32'(y), 0);
        chk("mid_rst_valid", 32'(pif.pix_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(frame_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_busy", 32'(busy), 0);
            chk("post_rst_valid", 32'(pif.pix_valid), 0);
            chk("post_rst_done", 32'(frame_done), 0);
        end

        // RENDER_LAT=1 instance: two cycles per pixel.
        pif1.pix_ready = 1'b1;
        fs1 = 1'b1;
        step();
        fs1 = 1'b0;
        chk("rl1_x0", 32'(x1), 0);
        chk("rl1_valid0", 32'(pif1.pix_valid), 0);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("rl1_valid", 32'(pif1.pix_valid), 32'(i % 2));
            chk("rl1_x", 32'(x1), 32'(i / 2));
            chk("rl1_y", 32'(y1), 0);
            if (i % 2 == 1) chk("rl1_data", 32'(pif1.pix_data), 32'((i / 2) * 128));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
